mlp_feature_loader: RTL and testbench
=====================================

Name: mlp_feature_loader

Overview:
- Sequential front-end for the combinational cardio MLP classifier (84-bit `inp`, 2-bit `out`, 63-bit `predo`).
- Accepts features one per transfer over a valid/ready stream and packs one frame into the classifier input vector.
- Holds that vector stable while the classifier settles, then captures class index and raw scores.
- Presents the captured result on a valid/ready output until it is consumed.

Parameters:
- NUM_FEAT, 21, features per frame.
- FEAT_W, 4, bits per feature (unsigned).
- CLASS_W, 2, classifier class-index width.
- PRED_W, 63, classifier raw-score bus width.
- SETTLE_CYC, 2, cycles the packed vector is held before capture; legal range 1..15.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- s_valid  in  1  feature-stream valid.
- s_ready  out  1  feature-stream ready.
- s_data  in  FEAT_W  feature value.
- s_last  in  1  marks final feature of a frame.
- inp_o  out  NUM_FEAT*FEAT_W  packed vector to classifier `inp`.
- out_i  in  CLASS_W  classifier class index.
- predo_i  in  PRED_W  classifier raw scores.
- m_valid  out  1  result valid.
- m_ready  in  1  result consumer ready.
- m_class  out  CLASS_W  captured class index.
- m_pred  out  PRED_W  captured raw scores.
- frame_err  out  1  one-cycle pulse on a malformed frame.

Behaviour:
- Reset (rst high at edge):
  - State goes to COLLECT and feat_cnt to 0.
  - inp_o, m_class, m_pred, m_valid and frame_err all go to 0.
  - s_ready is 0 while rst is high.
- States: COLLECT, SETTLE, HOLD.
- s_ready = (state==COLLECT) && !rst, decoded combinationally from state.
- COLLECT:
  - A transfer is s_valid && s_ready at an edge.
  - Each transfer writes s_data into inp_o[FEAT_W*feat_cnt +: FEAT_W]; feature 0 occupies bits [3:0] and feature 20 occupies [83:80].
  - A transfer with feat_cnt < NUM_FEAT-1 increments feat_cnt.
- Frame end, on a transfer with feat_cnt == NUM_FEAT-1:
  - With s_last=1: the value is written, state goes to SETTLE and settle_cnt to 0.
  - With s_last=0: frame_err pulses, the value is discarded, inp_o clears to 0 and feat_cnt returns to 0. State stays COLLECT.
- Early s_last (transfer with s_last=1 and feat_cnt < NUM_FEAT-1): frame_err pulses, inp_o clears, feat_cnt returns to 0, state stays COLLECT.
- SETTLE:
  - inp_o is frozen.
  - settle_cnt increments each edge.
  - At the edge where settle_cnt == SETTLE_CYC-1: out_i is registered into m_class, predo_i into m_pred, m_valid goes to 1 and state goes to HOLD.
- Latency: if the last feature is accepted at edge E0, m_valid is high after edge E0+SETTLE_CYC.
- HOLD:
  - inp_o, m_class and m_pred are frozen.
  - On an edge with m_valid && m_ready: m_valid goes to 0, feat_cnt goes to 0 and state goes to COLLECT.
  - inp_o keeps the old frame until it is overwritten.
  - s_ready rises the cycle after the handshake; there is no same-cycle bypass.
- m_ready is ignored outside HOLD. s_valid is ignored outside COLLECT.
- frame_err is high for exactly one cycle per malformed frame; otherwise 0.
- Widths:
  - feat_cnt is 5 bits and never exceeds NUM_FEAT-1.
  - settle_cnt is 4 bits.
  - There is no arithmetic on data; features and scores pass bit-exact.
- Reset mid-operation (rst in any state): the partial frame or pending result is lost, and all outputs return to their reset values on that edge.

Decomposition:
- Shared package mlp_pkg holds:
  - constants NUM_FEAT=21, FEAT_W=4, CLASS_W=2, PRED_W=63, INP_W=NUM_FEAT*FEAT_W;
  - the loader state enum {COLLECT, SETTLE, HOLD}.
- One sub-module, mlp_feat_pack: a write-indexed FEAT_W-slice register file with clear and hold controls, producing inp_o.
- The FSM, counters and result registers stay in the top.

Test Plan:
1. Indexed packing: reset for 2 cycles, then send features k&0xF for k=0..20 with s_last on k=20 and the classifier stubbed with out_i=2'b10, predo_i=63'h1234 → inp_o[3:0]=0, inp_o[63:60]=0xF, inp_o[83:80]=4; m_valid rises 2 edges after the last transfer with m_class=2, m_pred=63'h1234; s_ready=0 during SETTLE/HOLD.
2. Output backpressure: hold m_ready=0 for 10 cycles in HOLD and change out_i meanwhile → m_class and m_valid stay stable; after m_ready=1 for one edge, m_valid=0 and s_ready=1 on the next cycle.
3. Early s_last: s_last at feature 5 → frame_err is high for 1 cycle, inp_o=0, next frame of 21 features is accepted normally.
4. Missing s_last: 21st feature with s_last=0 → frame_err pulses, no m_valid, feat_cnt=0.
5. Gapped input: random s_valid gaps (50% duty) → packing is identical to scenario 1; SETTLE_CYC=1 build gives m_valid 1 edge after the last transfer.
6. Reset mid-operation: assert rst during SETTLE, then separately in HOLD → m_valid=0, inp_o=0 and state is COLLECT after the reset edge; a subsequent frame completes correctly.

Source files
------------

// File: rtl/mlp_pkg.sv
// Shared constants and loader state encoding for the cardio MLP front-end.
package mlp_pkg;
   localparam int NUM_FEAT = 21;
   localparam int FEAT_W   = 4;
   localparam int CLASS_W  = 2;
   localparam int PRED_W   = 63;
   localparam int INP_W    = NUM_FEAT * FEAT_W;

   typedef enum logic [1:0] {
      COLLECT = 2'd0,
      SETTLE  = 2'd1,
      HOLD    = 2'd2
   } loader_state_t;
endpackage

// File: rtl/mlp_feature_loader_if.sv
// Feature-stream input and result-stream output handshakes of the loader.
interface mlp_feature_loader_if;
   import mlp_pkg::*;

   logic               s_valid;
   logic               s_ready;
   logic [FEAT_W-1:0]  s_data;
   logic               s_last;
   logic               m_valid;
   logic               m_ready;
   logic [CLASS_W-1:0] m_class;
   logic [PRED_W-1:0]  m_pred;

   modport slave (
      input  s_valid, s_data, s_last, m_ready,
      output s_ready, m_valid, m_class, m_pred
   );

   modport master (
      output s_valid, s_data, s_last, m_ready,
      input  s_ready, m_valid, m_class, m_pred
   );
endinterface

// File: rtl/mlp_feat_pack.sv
// Write-indexed FEAT_W-slice register file forming the classifier input vector.
module mlp_feat_pack
   import mlp_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              wr_en,
   input  logic [4:0]        wr_idx,
   input  logic [FEAT_W-1:0] wr_data,
   input  logic              clr,
   input  logic              hold,
   output logic [INP_W-1:0]  inp_o
);

   always_ff @(posedge clk) begin
      if (rst || clr)
         inp_o <= '0;
      else if (wr_en && !hold)
         inp_o[FEAT_W*wr_idx +: FEAT_W] <= wr_data;
   end

endmodule

// File: rtl/mlp_feature_loader.sv
// Sequential front-end: packs a feature frame, lets the classifier settle, captures its result.
//
// state   | meaning
// COLLECT | accepting features into inp_o, feat_cnt = next slot
// SETTLE  | inp_o frozen, counting settle cycles before capture
// HOLD    | result presented on m_*, waiting for m_ready
module mlp_feature_loader
   import mlp_pkg::*;
#(
   parameter int SETTLE_CYC = 2
) (
   input  logic                 clk,
   input  logic                 rst,
   mlp_feature_loader_if.slave  sif,
   output logic [INP_W-1:0]     inp_o,
   input  logic [CLASS_W-1:0]   out_i,
   input  logic [PRED_W-1:0]    predo_i,
   output logic                 frame_err
);

   localparam logic [4:0] LAST_IDX    = 5'(NUM_FEAT - 1);
   localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYC - 1);

   loader_state_t state;
   logic [4:0]    feat_cnt;
   logic [3:0]    settle_cnt;
   logic          xfer;
   logic          last_slot;
   logic          bad_frame;

   assign sif.s_ready = (state == COLLECT) && !rst;
   assign xfer        = sif.s_valid && sif.s_ready;
   assign last_slot   = (feat_cnt == LAST_IDX);
   // s_last must coincide exactly with the final slot; any disagreement drops the frame
   assign bad_frame   = xfer && (sif.s_last != last_slot);

   mlp_feat_pack u_pack (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (xfer && !bad_frame),
      .wr_idx  (feat_cnt),
      .wr_data (sif.s_data),
      .clr     (bad_frame),
      .hold    (state != COLLECT),
      .inp_o   (inp_o)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= COLLECT;
         feat_cnt    <= '0;
         settle_cnt  <= '0;
         sif.m_valid <= 1'b0;
         sif.m_class <= '0;
         sif.m_pred  <= '0;
         frame_err   <= 1'b0;
      end else begin
         frame_err <= 1'b0;
         case (state)
            COLLECT: begin
               if (bad_frame) begin
                  frame_err <= 1'b1;
                  feat_cnt  <= '0;
               end else if (xfer) begin
                  if (last_slot) begin
                     state      <= SETTLE;
                     settle_cnt <= '0;
                  end else begin
                     feat_cnt <= feat_cnt + 5'd1;
                  end
               end
            end
            SETTLE: begin
               settle_cnt <= settle_cnt + 4'd1;
               if (settle_cnt == SETTLE_LAST) begin
                  sif.m_class <= out_i;
                  sif.m_pred  <= predo_i;
                  sif.m_valid <= 1'b1;
                  state       <= HOLD;
               end
            end
            HOLD: begin
               if (sif.m_valid && sif.m_ready) begin
                  sif.m_valid <= 1'b0;
                  feat_cnt    <= '0;
                  state       <= COLLECT;
               end
            end
            default: state <= COLLECT;
         endcase
      end
   end

endmodule

// File: tb/tb_mlp_feature_loader.sv
// Directed bench: two loaders (SETTLE_CYC 2 and 1) run in lockstep on one stream.
module tb_mlp_feature_loader;
   import mlp_pkg::*;

   logic               clk;
   logic               rst;
   logic [CLASS_W-1:0] out_i;
   logic [PRED_W-1:0]  predo_i;
   logic [INP_W-1:0]   inp1, inp2;
   logic               fe1, fe2;
   int                 n_chk = 0;
   int                 n_bad = 0;
   logic [INP_W-1:0]   exp_inp;

   mlp_feature_loader_if if1 ();
   mlp_feature_loader_if if2 ();

   assign if2.s_valid = if1.s_valid;
   assign if2.s_data  = if1.s_data;
   assign if2.s_last  = if1.s_last;
   assign if2.m_ready = if1.m_ready;

   mlp_feature_loader #(.SETTLE_CYC(2)) dut (
      .clk(clk), .rst(rst), .sif(if1), .inp_o(inp1),
      .out_i(out_i), .predo_i(predo_i), .frame_err(fe1)
   );

   mlp_feature_loader #(.SETTLE_CYC(1)) dut_s1 (
      .clk(clk), .rst(rst), .sif(if2), .inp_o(inp2),
      .out_i(out_i), .predo_i(predo_i), .frame_err(fe2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [INP_W-1:0] frame_vec(input int mul, input int add);
      logic [INP_W-1:0] v;
      v = '0;
      for (int k = 0; k < NUM_FEAT; k++)
         v[FEAT_W*k +: FEAT_W] = 4'((k * mul + add) & 15);
      return v;
   endfunction

   // One transfer; optionally inserts a random idle cycle first
   task automatic send(input logic [3:0] d, input logic last, input bit gaps);
      int n;
      if (gaps && ($urandom_range(0, 1) == 1)) tick();
      if1.s_valid = 1'b1;
      if1.s_data  = d;
      if1.s_last  = last;
      n = 0;
      while (!if1.s_ready && n < 50) begin
         tick();
         n++;
      end
      if (n >= 50) chk("s_ready_timeout", 0, 1);
      tick();
      if1.s_valid = 1'b0;
      if1.s_last  = 1'b0;
   endtask

   task automatic send_frame(input int mul, input int add, input bit gaps);
      for (int k = 0; k < NUM_FEAT; k++)
         send(4'((k * mul + add) & 15), k == NUM_FEAT - 1, gaps);
   endtask

   task automatic wait_valid();
      int n;
      n = 0;
      while (!if1.m_valid && n < 20) begin
         tick();
         n++;
      end
      if (n >= 20) chk("m_valid_timeout", 0, 1);
   endtask

   task automatic consume();
      if1.m_ready = 1'b1;
      tick();
      if1.m_ready = 1'b0;
   endtask

   initial begin
      rst = 1'b1;
      if1.s_valid = 1'b0;
      if1.s_data  = '0;
      if1.s_last  = 1'b0;
      if1.m_ready = 1'b0;
      out_i   = 2'b10;
      predo_i = 63'h1234;

      // 1: indexed packing and latency
      tick();
      tick();
      chk("rst_inp", inp1, 0);
      chk("rst_mvalid", if1.m_valid, 0);
      chk("rst_sready", if1.s_ready, 0);
      chk("rst_ferr", fe1, 0);
      rst = 1'b0;
      #1;
      chk("sready_after_rst", if1.s_ready, 1);
      send_frame(1, 0, 1'b0);
      exp_inp = frame_vec(1, 0);
      chk("pack_f0", inp1[3:0], 4'h0);
      chk("pack_f15", inp1[63:60], 4'hF);
      chk("pack_f20", inp1[83:80], 4'h4);
      chk("pack_all", inp1, exp_inp);
      chk("settle_sready", if1.s_ready, 0);
      chk("settle_mvalid", if1.m_valid, 0);
      tick();
      chk("e1_mvalid", if1.m_valid, 0);
      chk("s1_e1_mvalid", if2.m_valid, 1);
      chk("s1_class", if2.m_class, 2'b10);
      tick();
      chk("e2_mvalid", if1.m_valid, 1);
      chk("e2_class", if1.m_class, 2'b10);
      chk("e2_pred", if1.m_pred, 63'h1234);
      chk("hold_sready", if1.s_ready, 0);

      // 2: output backpressure
      out_i   = 2'b01;
      predo_i = 63'h5;
      for (int i = 0; i < 10; i++) tick();
      chk("bp_mvalid", if1.m_valid, 1);
      chk("bp_class", if1.m_class, 2'b10);
      chk("bp_pred", if1.m_pred, 63'h1234);
      chk("bp_inp", inp1, exp_inp);
      consume();
      chk("rel_mvalid", if1.m_valid, 0);
      chk("rel_sready", if1.s_ready, 1);
      chk("rel_inp_kept", inp1, exp_inp);

      // 3: early s_last at feature 5
      for (int k = 0; k < 6; k++) send(4'(k + 7), k == 5, 1'b0);
      chk("early_ferr", fe1, 1);
      chk("early_inp", inp1, 0);
      tick();
      chk("early_ferr_pulse", fe1, 0);
      out_i   = 2'b11;
      predo_i = 63'h7FFF_0000_ABCD_0001;
      send_frame(3, 1, 1'b0);
      wait_valid();
      chk("early_next_class", if1.m_class, 2'b11);
      chk("early_next_pred", if1.m_pred, 63'h7FFF_0000_ABCD_0001);
      chk("early_next_inp", inp1, frame_vec(3, 1));
      consume();

      // 4: missing s_last on the 21st feature
      for (int k = 0; k < NUM_FEAT; k++) send(4'(k + 2), 1'b0, 1'b0);
      chk("miss_ferr", fe1, 1);
      chk("miss_inp", inp1, 0);
      tick();
      chk("miss_ferr_pulse", fe1, 0);
      tick();
      tick();
      chk("miss_no_mvalid", if1.m_valid, 0);
      chk("miss_sready", if1.s_ready, 1);

      // 5: gapped input, also proves feat_cnt restarted at 0
      out_i   = 2'b10;
      predo_i = 63'h1234;
      send_frame(1, 0, 1'b1);
      chk("gap_inp", inp1, frame_vec(1, 0));
      chk("gap_mvalid_e0", if1.m_valid, 0);
      tick();
      chk("gap_s1_mvalid", if2.m_valid, 1);
      chk("gap_s1_inp", inp2, frame_vec(1, 0));
      chk("gap_mvalid_e1", if1.m_valid, 0);
      tick();
      chk("gap_mvalid_e2", if1.m_valid, 1);
      chk("gap_pred", if1.m_pred, 63'h1234);
      consume();

      // 6: reset during SETTLE, then during HOLD
      send_frame(5, 2, 1'b0);
      rst = 1'b1;
      tick();
      chk("rstS_mvalid", if1.m_valid, 0);
      chk("rstS_inp", inp1, 0);
      chk("rstS_sready", if1.s_ready, 0);
      rst = 1'b0;
      #1;
      chk("rstS_collect", if1.s_ready, 1);
      send_frame(5, 2, 1'b0);
      wait_valid();
      rst = 1'b1;
      tick();
      chk("rstH_mvalid", if1.m_valid, 0);
      chk("rstH_inp", inp1, 0);
      chk("rstH_class", if1.m_class, 0);
      rst = 1'b0;
      #1;
      chk("rstH_collect", if1.s_ready, 1);
      out_i   = 2'b01;
      predo_i = 63'h4000_0000_0000_0000;
      send_frame(7, 3, 1'b0);
      wait_valid();
      chk("post_rst_class", if1.m_class, 2'b01);
      chk("post_rst_pred", if1.m_pred, 63'h4000_0000_0000_0000);
      chk("post_rst_inp", inp1, frame_vec(7, 3));
      consume();

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule
